// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter. Requester 0 (CPU) and requester 1 (loader/DMA)
// share one registered memory port. Each grant runs a fixed four-state
// sequence IDLE -> MEM -> RESP -> DONE. The ack pulse is one cycle long and
// is high only while the FSM is in DONE.
module mem_arbiter #(
    parameter int FIXED_PRIO   = 0,  // 0: round-robin on ties, 1: m0 always wins ties
    parameter int RST_PC_OWNER = 0   // last-served owner after reset (0: m1, so m0 wins first tie)
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_m0_req,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wrdata,
    input  logic [1:0]  i_m0_size,
    input  logic        i_m0_we,
    output logic        o_m0_ack,
    input  logic        i_m1_req,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wrdata,
    input  logic [1:0]  i_m1_size,
    input  logic        i_m1_we,
    output logic        o_m1_ack,
    output logic [31:0] o_rddata,
    output logic        o_busy,
    output logic [31:0] o_addr,
    output logic [31:0] o_wrdata,
    output logic [1:0]  o_size,
    output logic        o_we,
    input  logic [31:0] i_rddata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic any_req;
    logic grant_m1;        // winner chosen this cycle if a grant is made
    logic win_m1;          // winner of the transaction in flight
    logic m0_served_last;  // 1: m0 got the most recent grant, 0: m1 did

    // Winner selection and next-state decode.
    always_comb begin
        any_req   = i_m0_req | i_m1_req;
        grant_m1  = i_m1_req & (~i_m0_req | ((FIXED_PRIO == 0) & m0_served_last));
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = MEM;
            MEM:     state_nxt = RESP;
            RESP:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Memory port: loaded only on a grant; write strobe lasts exactly the MEM cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_addr   <= 32'h0;
            o_wrdata <= 32'h0;
            o_size   <= 2'b11;
            o_we     <= 1'b1;
        end else if (state == IDLE && any_req) begin
            o_addr   <= grant_m1 ? i_m1_addr   : i_m0_addr;
            o_wrdata <= grant_m1 ? i_m1_wrdata : i_m0_wrdata;
            o_size   <= grant_m1 ? i_m1_size   : i_m0_size;
            o_we     <= grant_m1 ? i_m1_we     : i_m0_we;
        end else if (state == MEM) begin
            o_we     <= 1'b1;
        end
    end

    // Winner and last-served tracking; the flag only moves when a grant is made.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            win_m1         <= 1'b0;
            m0_served_last <= (RST_PC_OWNER != 0);
        end else if (state == IDLE && any_req) begin
            win_m1         <= grant_m1;
            m0_served_last <= ~grant_m1;
        end
    end

    // Response: capture read data and raise the winner's ack for the DONE cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_rddata <= 32'h0;
            o_m0_ack <= 1'b0;
            o_m1_ack <= 1'b0;
        end else if (state == RESP) begin
            o_rddata <= i_rddata;
            o_m0_ack <= ~win_m1;
            o_m1_ack <= win_m1;
        end else if (state == DONE) begin
            o_m0_ack <= 1'b0;
            o_m1_ack <= 1'b0;
        end
    end

    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance wired to a small
// synchronous memory model, plus a fixed-priority instance for tie checks.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m0_wrdata, m1_addr, m1_wrdata;
    logic [1:0]  m0_size, m1_size;
    logic        m0_we, m1_we;
    logic        ack0, ack1, busy, we;
    logic [31:0] rddata, addr, wrdata;
    logic [1:0]  size;
    logic [31:0] mem_rd;

    logic        f_m0_req, f_m1_req;
    logic        f_ack0, f_ack1, f_busy, f_we;
    logic [31:0] f_rddata, f_addr, f_wrdata;
    logic [1:0]  f_size;

    logic [31:0] mem [0:255];
    logic        preload;

    int n_checks = 0;
    int n_fail   = 0;
    int we_low_cnt = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.FIXED_PRIO(0), .RST_PC_OWNER(0)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_req(m0_req), .i_m0_addr(m0_addr), .i_m0_wrdata(m0_wrdata),
        .i_m0_size(m0_size), .i_m0_we(m0_we), .o_m0_ack(ack0),
        .i_m1_req(m1_req), .i_m1_addr(m1_addr), .i_m1_wrdata(m1_wrdata),
        .i_m1_size(m1_size), .i_m1_we(m1_we), .o_m1_ack(ack1),
        .o_rddata(rddata), .o_busy(busy), .o_addr(addr), .o_wrdata(wrdata),
        .o_size(size), .o_we(we), .i_rddata(mem_rd)
    );

    mem_arbiter #(.FIXED_PRIO(1), .RST_PC_OWNER(0)) dut_fp (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_req(f_m0_req), .i_m0_addr(m0_addr), .i_m0_wrdata(m0_wrdata),
        .i_m0_size(m0_size), .i_m0_we(m0_we), .o_m0_ack(f_ack0),
        .i_m1_req(f_m1_req), .i_m1_addr(m1_addr), .i_m1_wrdata(m1_wrdata),
        .i_m1_size(m1_size), .i_m1_we(m1_we), .o_m1_ack(f_ack1),
        .o_rddata(f_rddata), .o_busy(f_busy), .o_addr(f_addr), .o_wrdata(f_wrdata),
        .o_size(f_size), .o_we(f_we), .i_rddata(mem_rd)
    );

    // Synchronous memory: samples the port every edge, little-endian byte lanes.
    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 256; k++) mem[k] <= 32'h0;
            mem[64] <= 32'hDEADBEEF;
        end else if (we === 1'b0) begin
            case (size)
                2'b00:   mem[addr[9:2]][8*addr[1:0] +: 8]   <= wrdata[7:0];
                2'b10:   mem[addr[9:2]][16*addr[1] +: 16]   <= wrdata[15:0];
                default: mem[addr[9:2]]                     <= wrdata;
            endcase
        end
        mem_rd <= mem[addr[9:2]];
    end

    always @(negedge clk) if (we === 1'b0) we_low_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    int ack_at [4];
    int ack_who [4];
    int n_acks;
    int both_hi;
    int f_ack0_cnt;
    int f_ack1_first;

    initial begin
        rst_n = 1'b0; preload = 1'b1;
        m0_req = 0; m0_addr = 0; m0_wrdata = 0; m0_size = 2'b11; m0_we = 1;
        m1_req = 0; m1_addr = 0; m1_wrdata = 0; m1_size = 2'b11; m1_we = 1;
        f_m0_req = 0; f_m1_req = 0;

        // Reset values
        tick(); tick();
        check("rst_ack0", {31'b0, ack0}, 32'd0);
        check("rst_ack1", {31'b0, ack1}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_we", {31'b0, we}, 32'd1);
        check("rst_size", {30'b0, size}, 32'd3);
        check("rst_addr", addr, 32'd0);
        check("rst_wrdata", wrdata, 32'd0);
        check("rst_rddata", rddata, 32'd0);

        // Single m0 read, requested at the same edge reset releases
        rst_n = 1'b1; preload = 1'b0;
        m0_req = 1; m0_addr = 32'h100; m0_size = 2'b11; m0_we = 1;
        tick();
        check("rd_busy_grant", {31'b0, busy}, 32'd1);
        check("rd_addr", addr, 32'h100);
        check("rd_ack0_e1", {31'b0, ack0}, 32'd0);
        tick();
        check("rd_ack0_e2", {31'b0, ack0}, 32'd0);
        tick();
        check("rd_ack0_e3", {31'b0, ack0}, 32'd1);
        check("rd_ack1_e3", {31'b0, ack1}, 32'd0);
        check("rd_data", rddata, 32'hDEADBEEF);
        m0_req = 0;
        tick();
        check("rd_ack0_e4", {31'b0, ack0}, 32'd0);
        check("rd_idle", {31'b0, busy}, 32'd0);

        // m1 byte write to 0x203
        m1_req = 1; m1_addr = 32'h203; m1_wrdata = 32'hA5; m1_size = 2'b00; m1_we = 0;
        tick();
        check("wr_we_mem", {31'b0, we}, 32'd0);
        check("wr_addr", addr, 32'h203);
        check("wr_size", {30'b0, size}, 32'd0);
        tick();
        check("wr_we_resp", {31'b0, we}, 32'd1);
        tick();
        check("wr_ack1", {31'b0, ack1}, 32'd1);
        check("wr_ack0", {31'b0, ack0}, 32'd0);
        m1_req = 0; m1_we = 1; m1_size = 2'b11; m1_addr = 32'h200;
        tick();
        check("wr_we_low_cycles", we_low_cnt, 32'd1);
        // m0 reads the word back
        m0_req = 1; m0_addr = 32'h200;
        tick(); tick(); tick();
        check("rb_ack0", {31'b0, ack0}, 32'd1);
        check("rb_data", rddata, 32'hA500_0000);
        m0_req = 0;
        tick();

        // Round-robin tie after reset (m0 was served last before the reset)
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; m0_addr = 32'h100; m0_req = 1; m1_req = 1;
        n_acks = 0; both_hi = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (ack0 && ack1) both_hi++;
            if ((ack0 || ack1) && n_acks < 4) begin
                ack_at[n_acks] = i;
                ack_who[n_acks] = ack1 ? 1 : 0;
                n_acks++;
            end
        end
        m0_req = 0; m1_req = 0;
        check("rr_n_acks", n_acks, 32'd4);
        check("rr_both_high", both_hi, 32'd0);
        check("rr_first_ack_cycle", ack_at[0], 32'd3);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rr_who_%0d", k), ack_who[k], k % 2);
            if (k > 0) check($sformatf("rr_gap_%0d", k), ack_at[k] - ack_at[k-1], 32'd4);
        end

        // Reset during RESP of an m0 read
        m0_req = 1;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst_ack0", {31'b0, ack0}, 32'd0);
        check("mid_rst_ack1", {31'b0, ack1}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_we", {31'b0, we}, 32'd1);
        rst_n = 1'b1; m1_req = 1;
        tick();
        check("post_rst_grant_busy", {31'b0, busy}, 32'd1);
        check("post_rst_tie_addr", addr, 32'h100);
        tick(); tick();
        check("post_rst_ack0", {31'b0, ack0}, 32'd1);
        check("post_rst_ack1", {31'b0, ack1}, 32'd0);
        m0_req = 0;
        tick(); tick(); tick(); tick();
        check("held_m1_ack1", {31'b0, ack1}, 32'd1);
        check("held_m1_data", rddata, 32'hA500_0000);
        m1_req = 0;
        tick();

        // Late m1 request raised while m0 is in MEM
        m0_req = 1;
        tick();
        m1_req = 1;
        tick();
        check("late_addr_hold", addr, 32'h100);
        tick();
        check("late_ack0", {31'b0, ack0}, 32'd1);
        check("late_ack1_e3", {31'b0, ack1}, 32'd0);
        check("late_data", rddata, 32'hDEADBEEF);
        m0_req = 0;
        tick();
        check("late_idle", {31'b0, busy}, 32'd0);
        tick();
        check("late_m1_grant", {31'b0, busy}, 32'd1);
        check("late_m1_addr", addr, 32'h200);
        tick();
        check("late_ack1_e6", {31'b0, ack1}, 32'd0);
        tick();
        check("late_ack1_e7", {31'b0, ack1}, 32'd1);
        m1_req = 0;
        tick();

        // Fixed priority: m0 keeps requesting, m1 waits until m0 drops
        f_m0_req = 1; f_m1_req = 1;
        f_ack0_cnt = 0; f_ack1_first = -1; both_hi = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (f_ack0 && f_ack1) both_hi++;
            if (f_ack0) f_ack0_cnt++;
            if (f_ack1 && f_ack1_first < 0) f_ack1_first = i;
            if (i == 11) f_m0_req = 0;
        end
        f_m1_req = 0;
        check("fp_m0_acks", f_ack0_cnt, 32'd3);
        check("fp_m1_first_ack", f_ack1_first, 32'd15);
        check("fp_both_high", both_hi, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
